// File: rtl/ls_pkg.sv
// ls_pkg -- shared definitions for the load/store queue.
// Contents:
//   XLEN_DEF / ROB_W_DEF / OP_W_DEF  default data, ROB tag and opcode widths
//   ls_op_e                          load/store opcode encodings (LB..SW)
//   is_store()                       true for the store opcodes
package ls_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int ROB_W_DEF = 4;
  localparam int OP_W_DEF  = 6;

  // Bit 3 set marks the store group; loads occupy the low codes.
  typedef enum logic [5:0] {
    OP_LB  = 6'h00,
    OP_LH  = 6'h01,
    OP_LW  = 6'h02,
    OP_LBU = 6'h04,
    OP_LHU = 6'h05,
    OP_SB  = 6'h08,
    OP_SH  = 6'h09,
    OP_SW  = 6'h0A
  } ls_op_e;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsq_entry.sv
// lsq_entry -- one slot of the load/store queue: holds the instruction
// fields and tracks the two source operands, capturing them from dispatch
// or from the common data bus.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   en                 global enable; low freezes the slot
//   load               write the slot from the dispatch fields this cycle
//   occupied           slot holds a live instruction (enables wakeup)
//   d_*                dispatch fields (op, imm, rob_id, src_rdy/val/tag)
//   cdb_valid/tag/value result broadcast
//   op, imm, rob_id    stored instruction fields
//   src_rdy, src_val   operand presence bits and values (rs2 upper half)
module lsq_entry
  import ls_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ROB_W = ROB_W_DEF,
  parameter int OP_W  = OP_W_DEF
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic                 occupied,
  input  logic [OP_W-1:0]      d_op,
  input  logic [XLEN-1:0]      d_imm,
  input  logic [ROB_W-1:0]     d_rob_id,
  input  logic [1:0]           d_src_rdy,
  input  logic [2*XLEN-1:0]    d_src_val,
  input  logic [2*ROB_W-1:0]   d_src_tag,
  input  logic                 cdb_valid,
  input  logic [ROB_W-1:0]     cdb_tag,
  input  logic [XLEN-1:0]      cdb_value,
  output logic [OP_W-1:0]      op,
  output logic [XLEN-1:0]      imm,
  output logic [ROB_W-1:0]     rob_id,
  output logic [1:0]           src_rdy,
  output logic [2*XLEN-1:0]    src_val
);

  logic [2*ROB_W-1:0] src_tag;

  // A freshly dispatched operand that is still pending can be satisfied by
  // a broadcast in the very same cycle; otherwise an occupied slot listens
  // to the bus every cycle for its pending tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= '0;
      imm     <= '0;
      rob_id  <= '0;
      src_rdy <= '0;
      src_val <= '0;
      src_tag <= '0;
    end else if (en) begin
      if (load) begin
        op      <= d_op;
        imm     <= d_imm;
        rob_id  <= d_rob_id;
        src_tag <= d_src_tag;
        for (int i = 0; i < 2; i++) begin
          if (d_src_rdy[i]) begin
            src_rdy[i]                <= 1'b1;
            src_val[i*XLEN +: XLEN]   <= d_src_val[i*XLEN +: XLEN];
          end else if (cdb_valid && (cdb_tag == d_src_tag[i*ROB_W +: ROB_W])) begin
            src_rdy[i]                <= 1'b1;
            src_val[i*XLEN +: XLEN]   <= cdb_value;
          end else begin
            src_rdy[i]                <= 1'b0;
            src_val[i*XLEN +: XLEN]   <= d_src_val[i*XLEN +: XLEN];
          end
        end
      end else if (occupied && cdb_valid) begin
        for (int i = 0; i < 2; i++) begin
          if (!src_rdy[i] && (src_tag[i*ROB_W +: ROB_W] == cdb_tag)) begin
            src_rdy[i]              <= 1'b1;
            src_val[i*XLEN +: XLEN] <= cdb_value;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ls_queue.sv
// ls_queue -- in-order load/store queue. Instructions enter at the tail,
// wait for their operands (with bus wakeup), and issue strictly from the
// head. Loads leave at issue; stores stay at the head until the ROB commits
// them, which keeps younger memory operations behind an uncommitted store.
// Ports:
//   clk, rst, rdy            clock, async active-high reset, global enable
//   disp_*                   dispatch request and instruction fields
//   full, count              occupancy status
//   cdb_*                    result broadcast for operand wakeup
//   commit_valid/rob_id      store release from the ROB
//   flush                    misprediction rollback, empties the queue
//   lsu_ready                LSU can accept an operation
//   lsu_valid, lsu_*         registered one-cycle issue pulse and fields
module ls_queue
  import ls_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = XLEN_DEF,
  parameter int ROB_W = ROB_W_DEF,
  parameter int OP_W  = OP_W_DEF
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    disp_valid,
  input  logic [OP_W-1:0]         disp_op,
  input  logic [XLEN-1:0]         disp_imm,
  input  logic [ROB_W-1:0]        disp_rob_id,
  input  logic [1:0]              disp_src_rdy,
  input  logic [2*XLEN-1:0]       disp_src_val,
  input  logic [2*ROB_W-1:0]      disp_src_tag,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    cdb_valid,
  input  logic [ROB_W-1:0]        cdb_tag,
  input  logic [XLEN-1:0]         cdb_value,
  input  logic                    commit_valid,
  input  logic [ROB_W-1:0]        commit_rob_id,
  input  logic                    flush,
  input  logic                    lsu_ready,
  output logic                    lsu_valid,
  output logic [OP_W-1:0]         lsu_op,
  output logic [2*XLEN-1:0]       lsu_src,
  output logic [XLEN-1:0]         lsu_imm,
  output logic [ROB_W-1:0]        lsu_rob_id
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0]   valid;
  logic [DEPTH-1:0]   issued;
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;

  logic [OP_W-1:0]    e_op      [DEPTH];
  logic [XLEN-1:0]    e_imm     [DEPTH];
  logic [ROB_W-1:0]   e_rob     [DEPTH];
  logic [1:0]         e_src_rdy [DEPTH];
  logic [2*XLEN-1:0]  e_src_val [DEPTH];

  logic push;
  logic head_store;
  logic issue;
  logic commit_pop;
  logic pop;

  assign full = (count == CW'(DEPTH));

  // Fullness is judged on the count at the start of the cycle, so a pop in
  // the same cycle never makes room for a dispatch.
  assign push       = disp_valid && !full;
  assign head_store = is_store(6'(e_op[head]));
  assign issue      = (count != '0) && valid[head] && !issued[head]
                      && (&e_src_rdy[head]) && lsu_ready;
  assign commit_pop = commit_valid && valid[head] && issued[head] && head_store
                      && (commit_rob_id == e_rob[head]);
  assign pop        = (issue && !head_store) || commit_pop;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic load_en;
    assign load_en = push && !flush && (tail == AW'(g));

    lsq_entry #(
      .XLEN  (XLEN),
      .ROB_W (ROB_W),
      .OP_W  (OP_W)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .en        (rdy),
      .load      (load_en),
      .occupied  (valid[g]),
      .d_op      (disp_op),
      .d_imm     (disp_imm),
      .d_rob_id  (disp_rob_id),
      .d_src_rdy (disp_src_rdy),
      .d_src_val (disp_src_val),
      .d_src_tag (disp_src_tag),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .op        (e_op[g]),
      .imm       (e_imm[g]),
      .rob_id    (e_rob[g]),
      .src_rdy   (e_src_rdy[g]),
      .src_val   (e_src_val[g])
    );
  end

  // Queue bookkeeping and the issue register. Flush wins over everything
  // else; an issued store only sets its issued bit and waits for commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= '0;
      issued     <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      lsu_valid  <= 1'b0;
      lsu_op     <= '0;
      lsu_src    <= '0;
      lsu_imm    <= '0;
      lsu_rob_id <= '0;
    end else if (rdy) begin
      if (flush) begin
        valid     <= '0;
        issued    <= '0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        lsu_valid <= 1'b0;
      end else begin
        lsu_valid <= issue;
        if (issue) begin
          lsu_op     <= e_op[head];
          lsu_src    <= e_src_val[head];
          lsu_imm    <= e_imm[head];
          lsu_rob_id <= e_rob[head];
          if (head_store) begin
            issued[head] <= 1'b1;
          end
        end
        if (push) begin
          valid[tail]  <= 1'b1;
          issued[tail] <= 1'b0;
          tail         <= tail + AW'(1);
        end
        if (pop) begin
          valid[head]  <= 1'b0;
          issued[head] <= 1'b0;
          head         <= head + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue -- scoreboard bench for ls_queue (DEPTH=4). Dispatched
// instructions are queued in issue order with operand values resolved by a
// reference model; a negedge monitor pops and compares on every issue pulse.
module tb_ls_queue;
  import ls_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int ROB_W = 4;
  localparam int OP_W  = 6;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rdy = 1'b1;
  logic               disp_valid = 1'b0;
  logic [OP_W-1:0]    disp_op = '0;
  logic [XLEN-1:0]    disp_imm = '0;
  logic [ROB_W-1:0]   disp_rob_id = '0;
  logic [1:0]         disp_src_rdy = '0;
  logic [2*XLEN-1:0]  disp_src_val = '0;
  logic [2*ROB_W-1:0] disp_src_tag = '0;
  logic               full;
  logic [CW-1:0]      count;
  logic               cdb_valid = 1'b0;
  logic [ROB_W-1:0]   cdb_tag = '0;
  logic [XLEN-1:0]    cdb_value = '0;
  logic               commit_valid = 1'b0;
  logic [ROB_W-1:0]   commit_rob_id = '0;
  logic               flush = 1'b0;
  logic               lsu_ready = 1'b0;
  logic               lsu_valid;
  logic [OP_W-1:0]    lsu_op;
  logic [2*XLEN-1:0]  lsu_src;
  logic [XLEN-1:0]    lsu_imm;
  logic [ROB_W-1:0]   lsu_rob_id;

  ls_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_imm(disp_imm),
    .disp_rob_id(disp_rob_id), .disp_src_rdy(disp_src_rdy),
    .disp_src_val(disp_src_val), .disp_src_tag(disp_src_tag),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .flush(flush), .lsu_ready(lsu_ready),
    .lsu_valid(lsu_valid), .lsu_op(lsu_op), .lsu_src(lsu_src),
    .lsu_imm(lsu_imm), .lsu_rob_id(lsu_rob_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]    op;
    logic [XLEN-1:0]    imm;
    logic [ROB_W-1:0]   rob;
    logic [1:0]         srdy;
    logic [2*XLEN-1:0]  sval;
    logic [2*ROB_W-1:0] stag;
  } exp_t;

  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               mcnt = 0;
  logic             head_store_issued = 1'b0;
  logic [ROB_W-1:0] head_store_tag = '0;
  logic             rdy_at_edge = 1'b0;
  logic [5:0]       op_tab [8];

  function automatic bit bench_is_store(input logic [OP_W-1:0] op);
    return (op == 6'(OP_SB)) || (op == 6'(OP_SH)) || (op == 6'(OP_SW));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model, evaluated once per cycle after the monitor has run.
  task automatic modelUpdate();
    exp_t t;
    bit   accept;
    if (!rdy) return;
    if (flush) begin
      exp_q.delete();
      mcnt = 0;
      head_store_issued = 1'b0;
      return;
    end
    accept = disp_valid && (mcnt < DEPTH);
    if (commit_valid && head_store_issued && (commit_rob_id == head_store_tag)) begin
      mcnt--;
      head_store_issued = 1'b0;
    end
    if (cdb_valid) begin
      foreach (exp_q[j]) begin
        t = exp_q[j];
        for (int s = 0; s < 2; s++) begin
          if (!t.srdy[s] && (t.stag[s*ROB_W +: ROB_W] == cdb_tag)) begin
            t.srdy[s] = 1'b1;
            t.sval[s*XLEN +: XLEN] = cdb_value;
          end
        end
        exp_q[j] = t;
      end
    end
    if (accept) begin
      t.op = disp_op; t.imm = disp_imm; t.rob = disp_rob_id;
      t.srdy = disp_src_rdy; t.sval = disp_src_val; t.stag = disp_src_tag;
      for (int s = 0; s < 2; s++) begin
        if (!t.srdy[s] && cdb_valid && (t.stag[s*ROB_W +: ROB_W] == cdb_tag)) begin
          t.srdy[s] = 1'b1;
          t.sval[s*XLEN +: XLEN] = cdb_value;
        end
      end
      exp_q.push_back(t);
      mcnt++;
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    #1;
    modelUpdate();
    @(posedge clk);
    #1;
    disp_valid = 1'b0;
    cdb_valid = 1'b0;
    commit_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic setDisp(input logic [5:0] op, input logic [31:0] imm, input logic [3:0] rob,
                         input logic [1:0] srdy, input logic [63:0] sval, input logic [7:0] stag);
    disp_valid = 1'b1; disp_op = op; disp_imm = imm; disp_rob_id = rob;
    disp_src_rdy = srdy; disp_src_val = sval; disp_src_tag = stag;
  endtask

  task automatic setCdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  always @(posedge clk) rdy_at_edge <= rdy;

  // Monitor: every fresh issue pulse must match the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && lsu_valid && rdy_at_edge) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("[TB] FAIL unexpected_issue: got rob %0h, expected no issue", lsu_rob_id);
      end else begin
        e = exp_q.pop_front();
        checkOutput("issue_operands_ready", 64'(e.srdy), 64'd3);
        checkOutput("issue_fields", 64'({lsu_op, lsu_rob_id, lsu_imm}), 64'({e.op, e.rob, e.imm}));
        checkOutput("issue_src", lsu_src, e.sval);
        if (bench_is_store(e.op)) begin
          head_store_issued = 1'b1;
          head_store_tag = e.rob;
        end else begin
          mcnt--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k, exp_cnt, guard, cycles;
    bit found;
    logic [3:0] ptag;
    op_tab = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_full", 64'(full), 64'd0);
    checkOutput("reset_lsu_valid", 64'(lsu_valid), 64'd0);
    checkOutput("reset_lsu_fields", 64'({lsu_op, lsu_rob_id, lsu_imm}), 64'd0);
    rst = 1'b0;

    // Fill to full, drop a fifth dispatch, drain in order
    lsu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setDisp(OP_LW, 32'h100 + 32'(i), 4'(i), 2'b11, {32'hA0 + 32'(i), 32'hB0 + 32'(i)}, 8'h00);
      applyStimulus();
      checkOutput("fill_count", 64'(count), 64'(i + 1));
    end
    checkOutput("fill_full", 64'(full), 64'd1);
    setDisp(OP_LW, 32'h999, 4'd15, 2'b11, 64'h55, 8'h00);
    applyStimulus();
    checkOutput("drop_count", 64'(count), 64'd4);
    lsu_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      applyStimulus();
      checkOutput("drain_count", 64'(count), 64'(i));
      checkOutput("drain_lsu_rob", 64'(lsu_rob_id), 64'(3 - i));
    end
    applyStimulus();
    checkOutput("drain_pulse_end", 64'(lsu_valid), 64'd0);

    // Wakeup from the bus
    setDisp(OP_LW, 32'h40, 4'd1, 2'b10, 64'h0, {4'd0, 4'd3});
    applyStimulus();
    applyStimulus();
    checkOutput("wait_no_issue", 64'(lsu_valid), 64'd0);
    setCdb(4'd3, 32'h1234);
    applyStimulus();
    applyStimulus();
    checkOutput("wake_issue", 64'(lsu_valid), 64'd1);
    checkOutput("wake_src", 64'(lsu_src[31:0]), 64'h1234);
    applyStimulus();
    checkOutput("wake_pulse_end", 64'(lsu_valid), 64'd0);

    // Dispatch bypass
    lsu_ready = 1'b0;
    setDisp(OP_LH, 32'h44, 4'd6, 2'b10, 64'h0, {4'd0, 4'd5});
    setCdb(4'd5, 32'hBEEF);
    applyStimulus();
    lsu_ready = 1'b1;
    applyStimulus();
    checkOutput("bypass_issue", 64'(lsu_valid), 64'd1);
    checkOutput("bypass_src", 64'(lsu_src[31:0]), 64'hBEEF);

    // Store holds younger load until commit
    lsu_ready = 1'b0;
    applyStimulus();
    setDisp(OP_SW, 32'h8, 4'd2, 2'b11, {32'hDA7A, 32'h2000}, 8'h00);
    applyStimulus();
    setDisp(OP_LW, 32'hC, 4'd4, 2'b11, {32'h0, 32'h3000}, 8'h00);
    applyStimulus();
    lsu_ready = 1'b1;
    applyStimulus();
    checkOutput("store_issue_rob", 64'({lsu_valid, lsu_rob_id}), 64'({1'b1, 4'd2}));
    checkOutput("store_retained", 64'(count), 64'd2);
    repeat (3) applyStimulus();
    checkOutput("load_blocked", 64'(lsu_valid), 64'd0);
    commit_valid = 1'b1; commit_rob_id = 4'd7;
    applyStimulus();
    checkOutput("bad_commit_ignored", 64'(count), 64'd2);
    commit_valid = 1'b1; commit_rob_id = 4'd2;
    applyStimulus();
    checkOutput("commit_pop", 64'({lsu_valid, count}), 64'({1'b0, 3'd1}));
    applyStimulus();
    checkOutput("load_after_commit", 64'({lsu_valid, lsu_rob_id, count}), 64'({1'b1, 4'd4, 3'd0}));

    // Flush beats dispatch and issue
    lsu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setDisp(OP_LBU, 32'(i), 4'(8 + i), 2'b11, 64'(i), 8'h00);
      applyStimulus();
    end
    checkOutput("preflush_count", 64'(count), 64'd3);
    setDisp(OP_LW, 32'h77, 4'd11, 2'b11, 64'h77, 8'h00);
    flush = 1'b1;
    lsu_ready = 1'b1;
    applyStimulus();
    checkOutput("flush_state", 64'({lsu_valid, count}), 64'd0);
    applyStimulus();
    checkOutput("postflush_state", 64'({lsu_valid, count}), 64'd0);

    // Global enable low holds state and the issue pulse
    lsu_ready = 1'b0;
    rdy = 1'b0;
    setDisp(OP_LW, 32'h50, 4'd6, 2'b11, 64'h6, 8'h00);
    applyStimulus();
    checkOutput("rdy_low_count", 64'(count), 64'd0);
    rdy = 1'b1;
    setDisp(OP_LW, 32'h50, 4'd6, 2'b11, 64'h6, 8'h00);
    applyStimulus();
    lsu_ready = 1'b1;
    applyStimulus();
    rdy = 1'b0;
    applyStimulus();
    checkOutput("rdy_low_hold_pulse", 64'(lsu_valid), 64'd1);
    rdy = 1'b1;
    applyStimulus();
    checkOutput("rdy_high_pulse_end", 64'(lsu_valid), 64'd0);

    // Asynchronous reset during an issue pulse
    lsu_ready = 1'b0;
    setDisp(OP_LW, 32'h60, 4'd9, 2'b11, 64'h9, 8'h00);
    applyStimulus();
    lsu_ready = 1'b1;
    applyStimulus();
    checkOutput("pre_reset_issue", 64'(lsu_valid), 64'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_reset_lsu_valid", 64'(lsu_valid), 64'd0);
    checkOutput("async_reset_count", 64'(count), 64'd0);
    exp_q.delete(); mcnt = 0; head_store_issued = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized rounds: fill with random operands, resolve, drain
    for (int r = 0; r < 30; r++) begin
      lsu_ready = 1'b0;
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) begin
        setDisp(op_tab[$urandom_range(0, 7)], $urandom, 4'($urandom), 2'($urandom),
                {$urandom, $urandom}, 8'($urandom));
        if ($urandom_range(0, 1) == 1) setCdb(4'($urandom), $urandom);
        applyStimulus();
      end
      exp_cnt = (k > DEPTH) ? DEPTH : k;
      checkOutput("rand_fill_count", 64'({full, count}), 64'({exp_cnt == DEPTH, 3'(exp_cnt)}));
      guard = 0;
      while (guard < 40) begin
        found = 1'b0;
        ptag = '0;
        foreach (exp_q[j]) begin
          for (int s = 0; s < 2; s++) begin
            if (!found && !exp_q[j].srdy[s]) begin
              found = 1'b1;
              ptag = exp_q[j].stag[s*ROB_W +: ROB_W];
            end
          end
        end
        if (!found) break;
        setCdb(ptag, $urandom);
        applyStimulus();
        guard++;
      end
      lsu_ready = 1'b1;
      cycles = 0;
      while (mcnt > 0 && cycles < 200) begin
        if (head_store_issued) begin
          commit_valid = 1'b1;
          commit_rob_id = head_store_tag;
        end
        applyStimulus();
        cycles++;
      end
      if (mcnt > 0) begin
        n_cmp++; n_err++;
        $display("[TB] FAIL rand_drain_timeout: got %0d entries left, expected 0", mcnt);
      end
      checkOutput("rand_drain_count", 64'(count), 64'd0);
    end

    lsu_ready = 1'b0;
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ls_queue.md
LS_QUEUE -- requirements
Module: ls_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, 2..64).
REQ-002 SHALL have parameter XLEN, default 32, data width.
REQ-003 SHALL have parameter ROB_W, default 4, ROB tag width.
REQ-004 SHALL have parameter OP_W, default 6, opcode width.
REQ-005 SHALL have port clk, in, 1, sole clock; all state rises on posedge.
REQ-006 SHALL have port rst, in, 1, asynchronous active-high reset.
REQ-007 SHALL have port rdy, in, 1, global enable; low means all state holds.
REQ-008 SHALL have port disp_valid, in, 1, dispatch request.
REQ-009 SHALL have port disp_op, in, OP_W, load/store opcode.
REQ-010 SHALL have port disp_imm, in, XLEN, offset.
REQ-011 SHALL have port disp_rob_id, in, ROB_W, ROB tag of instruction.
REQ-012 SHALL have port disp_src_rdy, in, 2, [0]=rs1 and [1]=rs2 operand value present.
REQ-013 SHALL have port disp_src_val, in, 2*XLEN, rs2 in the upper half, rs1 in the lower half.
REQ-014 SHALL have port disp_src_tag, in, 2*ROB_W, producer tags for operands not yet present.
REQ-015 SHALL have port full, out, 1, combinational, equal to (count==DEPTH).
REQ-016 SHALL have port count, out, $clog2(DEPTH)+1, occupied entries.
REQ-017 SHALL have port cdb_valid, in, 1, result broadcast valid.
REQ-018 SHALL have port cdb_tag, in, ROB_W, producing ROB tag.
REQ-019 SHALL have port cdb_value, in, XLEN, broadcast value.
REQ-020 SHALL have port commit_valid, in, 1, ROB releases a store.
REQ-021 SHALL have port commit_rob_id, in, ROB_W, tag of the released store.
REQ-022 SHALL have port flush, in, 1, misprediction rollback.
REQ-023 SHALL have port lsu_ready, in, 1, LSU can accept an operation.
REQ-024 SHALL have port lsu_valid, out, 1, registered one-cycle issue pulse.
REQ-025 SHALL have ports lsu_op/lsu_src/lsu_imm/lsu_rob_id, out, OP_W/2*XLEN/XLEN/ROB_W, issued entry fields.

Function
REQ-026 SHALL be a circular FIFO: head/tail wrap DEPTH-1->0; simultaneous push and pop leave count unchanged.
REQ-027 SHALL ignore disp_valid while full; no same-cycle pop credit applies.
REQ-028 SHALL, on enqueue, capture a not-ready operand as ready with cdb_value when cdb_valid is high and cdb_tag matches that cycle (dispatch bypass).
REQ-029 SHALL, each cycle with cdb_valid high, wake every occupied entry operand whose pending tag equals cdb_tag.
REQ-030 SHALL issue only the head entry, in order, when both operands are ready, the entry is not yet issued, lsu_ready is high and count>0; lsu_valid SHALL rise the next cycle for exactly one cycle.
REQ-031 SHALL pop a load at issue; SHALL mark a store issued and retain it at head until commit_valid && commit_rob_id==head tag, then pop it, with no issue in that cycle.
REQ-032 SHALL ignore commit_valid unless the head entry is an issued store with a matching tag.
REQ-033 SHALL give flush priority over dispatch, wakeup, issue and commit: next cycle count=0, head=tail=0, lsu_valid=0.
REQ-034 SHALL, while rdy is low, hold all state and outputs, including lsu_valid.

Reset
REQ-035 SHALL, on rst asserted asynchronously, clear count, head, tail, all entry-valid and issued bits, lsu_valid and all lsu_* fields to 0.

Structure
REQ-036 SHALL take opcode encodings (LB..SW), the is_store function and the XLEN/ROB_W defaults from shared package ls_pkg.
REQ-037 SHALL instantiate per-entry operand capture/wakeup as sub-module lsq_entry (DEPTH instances).

Verification
REQ-038 SHALL, with DEPTH=4 and 4 ready loads dispatched, show full=1; a 5th dispatch is dropped; lsu_ready=1 drains them in order, count 4->0.
REQ-039 SHALL, for a load waiting on tag 3 with cdb(tag 3, 0x1234) pulsed, show the load issue next cycle with lsu_src[31:0]=0x1234.
REQ-040 SHALL, for a dispatch with tag 5 while cdb tag 5 is valid in the same cycle, show the entry ready with no further broadcast.
REQ-041 SHALL, for a ready store (tag 2) followed by a load, issue the store, block the load until commit(tag 2), then issue the load; commit(tag 7) SHALL be ignored.
REQ-042 SHALL, with 3 entries plus a dispatch and flush in the same cycle, show count=0 and lsu_valid=0 next cycle; rst mid-issue SHALL clear lsu_valid immediately.
